// File: rtl/prog_sequencer_pkg.sv
// Shared constants for the program sequencer: sizes, state encoding and
// the layout of a program word {opcode, io_addr}.
package prog_sequencer_pkg;

    localparam int AW    = 4;            // log2 of program depth
    localparam int OPW   = 4;            // opcode width (ICU I input)
    localparam int IOW   = 4;            // I/O address width
    localparam int DEPTH = 1 << AW;      // 16 words
    localparam int W     = OPW + IOW;    // program word width

    // Field positions inside a program word
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int IO_MSB = 3;
    localparam int IO_LSB = 0;

    localparam logic [OPW-1:0] NOP = 4'h0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/prog_sequencer_if.sv
// Byte-wide program load port.
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high. The master holds load_valid/load_data stable
// until that edge; ready may be low for any number of cycles (nothing is
// dropped), and ready never depends on valid.
interface prog_sequencer_if;
    import prog_sequencer_pkg::*;

    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/prog_sequencer_mem.sv
// Program store: DEPTH x W register file, one synchronous write port and
// one asynchronous read port. Contents are not reset; prog_len tells the
// sequencer how much of it is valid.
module prog_sequencer_mem
    import prog_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Synchronous write of one program word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: loads {opcode, io_addr} words over the load port and
// replays them as a repeating scan, one registered opcode per clock on I.
module prog_sequencer
    import prog_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,        // async, active-low
    input  logic            load_en,
    input  logic            run,
    prog_sequencer_if.slave ld,
    output logic [OPW-1:0]  I,
    output logic [IOW-1:0]  io_addr,
    output logic [AW-1:0]   pc,
    output logic            running,
    output logic            scan_done,
    output logic [AW:0]     prog_len,
    output state_t          state_dbg
);

    state_t         state_q, state_d;
    // The write pointer always equals the number of words loaded, so one
    // register serves as both wptr and prog_len.
    logic [AW:0]    wptr_q, wptr_d;
    logic [AW-1:0]  pc_q, pc_d, pc_next;
    logic [OPW-1:0] i_q, i_d;
    logic [IOW-1:0] io_q, io_d;
    logic [AW-1:0]  rd_addr;
    logic [W-1:0]   rd_data;
    logic           wr_en;
    logic           last_word;

    prog_sequencer_mem u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr_q[AW-1:0]),
        .wdata (ld.load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign last_word     = ({1'b0, pc_q} == (wptr_q - (AW+1)'(1)));
    assign pc_next       = last_word ? '0 : pc_q + AW'(1);
    assign ld.load_ready = (state_q == S_LOAD) && !wptr_q[AW];
    assign wr_en         = ld.load_valid && ld.load_ready;

    // Next-state, counter and output-register values
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        pc_d    = pc_q;
        i_d     = NOP;
        io_d    = '0;
        rd_addr = '0;
        if (wr_en) wptr_d = wptr_q + (AW+1)'(1);
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                end else if (run && (wptr_q != '0)) begin
                    // mem[0] goes out on the same edge that enters RUN
                    state_d = S_RUN;
                    pc_d    = '0;
                    rd_addr = '0;
                    i_d     = rd_data[OP_MSB:OP_LSB];
                    io_d    = rd_data[IO_MSB:IO_LSB];
                end
            end
            S_LOAD: begin
                if (!load_en) state_d = S_IDLE;
            end
            S_RUN: begin
                if (load_en) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                end else if (!run) begin
                    state_d = S_IDLE;   // pc holds, I drops to NOP
                end else begin
                    rd_addr = pc_next;
                    pc_d    = pc_next;
                    i_d     = rd_data[OP_MSB:OP_LSB];
                    io_d    = rd_data[IO_MSB:IO_LSB];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered opcode/address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            pc_q    <= '0;
            i_q     <= NOP;
            io_q    <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            pc_q    <= pc_d;
            i_q     <= i_d;
            io_q    <= io_d;
        end
    end

    assign I         = i_q;
    assign io_addr   = io_q;
    assign pc        = pc_q;
    assign running   = (state_q == S_RUN);
    assign scan_done = (state_q == S_RUN) && last_word;
    assign prog_len  = wptr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer.
module tb_prog_sequencer;
    import prog_sequencer_pkg::*;

    logic            clk;
    logic            rst;
    logic            load_en;
    logic            run;
    logic [OPW-1:0]  I;
    logic [IOW-1:0]  io_addr;
    logic [AW-1:0]   pc;
    logic            running;
    logic            scan_done;
    logic [AW:0]     prog_len;
    state_t          state_dbg;

    prog_sequencer_if ld_if ();

    prog_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .run       (run),
        .ld        (ld_if),
        .I         (I),
        .io_addr   (io_addr),
        .pc        (pc),
        .running   (running),
        .scan_done (scan_done),
        .prog_len  (prog_len),
        .state_dbg (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    // Expected program contents, in load order
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        load_en = 1'b0;
        run = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.load_data = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // ---------------- driver ----------------
    // Load every word of exp_q back to back, then return to IDLE
    task automatic load_prog();
        load_en = 1'b1;
        tick();
        foreach (exp_q[k]) begin
            ld_if.load_valid = 1'b1;
            ld_if.load_data = exp_q[k];
            tick();
        end
        ld_if.load_valid = 1'b0;
        load_en = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if (I !== 4'h0 || io_addr !== 4'h0 || pc !== '0 || running !== 1'b0 ||
            scan_done !== 1'b0 || prog_len !== '0 || ld_if.load_ready !== 1'b0 ||
            state_dbg !== S_IDLE) begin
            bad++;
            $display("FAIL reset: I=%h io=%h pc=%0d run=%b sd=%b len=%0d rdy=%b st=%0d, want all zero",
                     I, io_addr, pc, running, scan_done, prog_len, ld_if.load_ready, state_dbg);
        end
    endtask

    task automatic test_basic_scan();
        exp_q = '{8'h1A, 8'h25, 8'h3F};
        load_prog();
        total++;
        if (prog_len !== 5'd3) begin
            bad++;
            $display("FAIL basic_len: prog_len=%0d want 3", prog_len);
        end
        run = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            total++;
            if (running !== 1'b1 || pc !== 4'(k % 3) || {I, io_addr} !== exp_q[k % 3] ||
                scan_done !== (k % 3 == 2)) begin
                bad++;
                $display("FAIL basic_scan[%0d]: run=%b pc=%0d I/io=%h sd=%b want 1 %0d %h %b",
                         k, running, pc, {I, io_addr}, scan_done, k % 3, exp_q[k % 3], (k % 3 == 2));
            end
            tick();
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        exp_q = {};
        load_en = 1'b1;
        tick();
        ld_if.load_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ld_if.load_data = (k < 16) ? {4'(k), 4'(15 - k)} : 8'hFF;
            if (k < 16) exp_q.push_back({4'(k), 4'(15 - k)});
            total++;
            if (ld_if.load_ready !== (k < 16)) begin
                bad++;
                $display("FAIL full_ready[%0d]: load_ready=%b want %b", k, ld_if.load_ready, (k < 16));
            end
            tick();
        end
        ld_if.load_valid = 1'b0;
        total++;
        if (prog_len !== 5'd16 || ld_if.load_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_len: prog_len=%0d rdy=%b want 16 0", prog_len, ld_if.load_ready);
        end
        load_en = 1'b0;
        tick();
        run = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            total++;
            if (pc !== 4'(k % 16) || {I, io_addr} !== exp_q[k % 16] || scan_done !== (k % 16 == 15)) begin
                bad++;
                $display("FAIL full_scan[%0d]: pc=%0d I/io=%h sd=%b want %0d %h %b",
                         k, pc, {I, io_addr}, scan_done, k % 16, exp_q[k % 16], (k % 16 == 15));
            end
            tick();
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_run_empty();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (running !== 1'b0 || I !== 4'h0 || state_dbg !== S_IDLE) begin
                bad++;
                $display("FAIL run_empty[%0d]: running=%b I=%h st=%0d want 0 0 0", k, running, I, state_dbg);
            end
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        load_en = 1'b1;
        run = 1'b1;
        tick();
        total++;
        if (state_dbg !== S_LOAD || ld_if.load_ready !== 1'b1 || I !== 4'h0 || running !== 1'b0) begin
            bad++;
            $display("FAIL priority: st=%0d rdy=%b I=%h running=%b want 1 1 0 0",
                     state_dbg, ld_if.load_ready, I, running);
        end
        load_en = 1'b0;
        run = 1'b0;
        tick();
    endtask

    task automatic test_stop_restart();
        exp_q = '{8'h1A, 8'h25, 8'h3F};
        load_prog();
        run = 1'b1;
        tick();
        tick();
        total++;
        if (pc !== 4'd1 || {I, io_addr} !== 8'h25) begin
            bad++;
            $display("FAIL stop_pre: pc=%0d I/io=%h want 1 25", pc, {I, io_addr});
        end
        run = 1'b0;
        tick();
        total++;
        if (I !== 4'h0 || io_addr !== 4'h0 || running !== 1'b0 || pc !== 4'd1) begin
            bad++;
            $display("FAIL stop: I=%h io=%h running=%b pc=%0d want 0 0 0 1", I, io_addr, running, pc);
        end
        run = 1'b1;
        tick();
        total++;
        if (pc !== 4'd0 || {I, io_addr} !== 8'h1A || running !== 1'b1) begin
            bad++;
            $display("FAIL restart: pc=%0d I/io=%h running=%b want 0 1a 1", pc, {I, io_addr}, running);
        end
        tick();
        // Leaves RUN active at pc=1 for the async reset test
    endtask

    task automatic test_async_reset_and_gaps();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (I !== 4'h0 || pc !== '0 || running !== 1'b0 || prog_len !== '0) begin
            bad++;
            $display("FAIL async_rst: I=%h pc=%0d running=%b len=%0d want 0 0 0 0",
                     I, pc, running, prog_len);
        end
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        // Valid toggles: only even steps handshake
        exp_q = {};
        load_en = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            ld_if.load_valid = (k % 2 == 0);
            ld_if.load_data = 8'h50 + 8'(k);
            if (k % 2 == 0) exp_q.push_back(8'h50 + 8'(k));
            tick();
        end
        ld_if.load_valid = 1'b0;
        load_en = 1'b0;
        tick();
        total++;
        if (prog_len !== 5'd4) begin
            bad++;
            $display("FAIL gaps_len: prog_len=%0d want 4", prog_len);
        end
        run = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            total++;
            if (pc !== 4'(k % 4) || {I, io_addr} !== exp_q[k % 4] || scan_done !== (k % 4 == 3)) begin
                bad++;
                $display("FAIL gaps_scan[%0d]: pc=%0d I/io=%h sd=%b want %0d %h %b",
                         k, pc, {I, io_addr}, scan_done, k % 4, exp_q[k % 4], (k % 4 == 3));
            end
            tick();
        end
        // load_en during RUN aborts the scan
        load_en = 1'b1;
        tick();
        total++;
        if (state_dbg !== S_LOAD || I !== 4'h0 || prog_len !== '0 || ld_if.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort: st=%0d I=%h len=%0d rdy=%b want 1 0 0 1",
                     state_dbg, I, prog_len, ld_if.load_ready);
        end
        load_en = 1'b0;
        run = 1'b0;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_scan();
        test_full_load();
        test_run_empty();
        test_priority();
        test_stop_restart();
        test_async_reset_and_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
